// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: processor write port, status flags and transmitter
// handshake for uart_tx_fifo. The slave modport is the FIFO side.
// The i_cts_n signal exists only when UART_TX_FIFO_CTS_EN is defined.
interface uart_tx_fifo_if #(
   parameter int DEPTH = 16
);
   localparam int PTR_W = $clog2(DEPTH);

   logic             i_wr_en;
   logic [7:0]       i_wr_data;
   logic             i_clr_overflow;
   logic             o_full;
   logic             o_empty;
   logic [PTR_W:0]   o_count;
   logic             o_overflow;
   logic [7:0]       o_tx_data;
   logic             o_tx_start;
   logic             i_tx_busy;
   logic             i_tx_done;
`ifdef UART_TX_FIFO_CTS_EN
   logic             i_cts_n;

   modport slave (
      input  i_wr_en, i_wr_data, i_clr_overflow, i_tx_busy, i_tx_done, i_cts_n,
      output o_full, o_empty, o_count, o_overflow, o_tx_data, o_tx_start
   );

   modport master (
      output i_wr_en, i_wr_data, i_clr_overflow, i_tx_busy, i_tx_done, i_cts_n,
      input  o_full, o_empty, o_count, o_overflow, o_tx_data, o_tx_start
   );
`else
   modport slave (
      input  i_wr_en, i_wr_data, i_clr_overflow, i_tx_busy, i_tx_done,
      output o_full, o_empty, o_count, o_overflow, o_tx_data, o_tx_start
   );

   modport master (
      output i_wr_en, i_wr_data, i_clr_overflow, i_tx_busy, i_tx_done,
      input  o_full, o_empty, o_count, o_overflow, o_tx_data, o_tx_start
   );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding a UART transmitter. Bytes are
// launched one at a time with a single-cycle start pulse, then the drain
// FSM waits for the transmitter's busy/done handshake before the next one.
// Optional flow control: define UART_TX_FIFO_CTS_EN to add the i_cts_n
// input (active-low, 2-flop synchronised) gating new launches.
//
// state    | meaning
// D_IDLE   | no byte in flight; launch when data present, tx idle, allowed
// D_LAUNCH | start pulse issued this cycle; waiting for tx busy
// D_WAIT   | transmitter busy with the byte; waiting for done pulse
module uart_tx_fifo #(
   parameter int DEPTH = 16
) (
   input logic          i_clk,
   input logic          i_rst,
   uart_tx_fifo_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      D_IDLE   = 2'd0,
      D_LAUNCH = 2'd1,
      D_WAIT   = 2'd2
   } drain_state_t;

   drain_state_t     state;
   drain_state_t     state_nxt;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             overflow;
   logic             tx_start;
   logic [7:0]       tx_data;

   logic             full;
   logic             empty;
   logic             wr_ok;
   logic             wr_rej;
   logic             pop;
   logic             launch_ok;

   assign full   = (count == CNT_FULL);
   assign empty  = (count == '0);
   assign wr_ok  = bus.i_wr_en & ~full;
   assign wr_rej = bus.i_wr_en & full;

`ifdef UART_TX_FIFO_CTS_EN
   logic cts_n_meta;
   logic cts_n_sync;

   // Bring the asynchronous clear-to-send into the clock domain; idle high
   // so nothing launches until the far end actually grants.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cts_n_meta <= 1'b1;
         cts_n_sync <= 1'b1;
      end else begin
         cts_n_meta <= bus.i_cts_n;
         cts_n_sync <= cts_n_meta;
      end
   end

   assign launch_ok = ~cts_n_sync;
`else
   assign launch_ok = 1'b1;
`endif

   // Drain FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= D_IDLE;
      else       state <= state_nxt;
   end

   // Drain FSM next state; pop marks the cycle a byte is taken for launch.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         D_IDLE: begin
            if (!empty && !bus.i_tx_busy && launch_ok) begin
               pop       = 1'b1;
               state_nxt = D_LAUNCH;
            end
         end
         D_LAUNCH: begin
            if (bus.i_tx_busy) state_nxt = D_WAIT;
         end
         D_WAIT: begin
            if (bus.i_tx_done) state_nxt = D_IDLE;
         end
         default: state_nxt = D_IDLE;
      endcase
   end

   // Storage array; contents need no reset since count gates every read.
   always_ff @(posedge i_clk) begin
      if (wr_ok) mem[wr_ptr] <= bus.i_wr_data;
   end

   // Pointers, occupancy, sticky overflow and registered launch outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
         case ({wr_ok, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         // A fresh overflow outranks a clear in the same cycle.
         if (wr_rej)                  overflow <= 1'b1;
         else if (bus.i_clr_overflow) overflow <= 1'b0;
         tx_start <= pop;
         if (pop) tx_data <= mem[rd_ptr];
      end
   end

   assign bus.o_full     = full;
   assign bus.o_empty    = empty;
   assign bus.o_count    = count;
   assign bus.o_overflow = overflow;
   assign bus.o_tx_start = tx_start;
   assign bus.o_tx_data  = tx_data;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a transmitter model
// (busy for 3 cycles after each start, then a one-cycle done) and a byte
// scoreboard filled on accepted writes and drained on each start pulse.
module tb_uart_tx_fifo;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_tx_fifo_if #(.DEPTH(DEPTH)) bus_if ();

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] sb [$];
   int         starts = 0;
   int         dones  = 0;
   int         busy_cnt = 0;
   logic       model_busy = 1'b0;
   logic       model_done = 1'b0;
   logic       hold_busy  = 1'b0;
   logic       prev_start = 1'b0;
   logic       busy_at_edge = 1'b0;

   assign bus_if.i_tx_busy = model_busy | hold_busy;
   assign bus_if.i_tx_done = model_done;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Busy as the DUT saw it at the edge that would have launched a byte.
   always @(posedge clk) busy_at_edge <= bus_if.i_tx_busy;

   // Transmitter model and scoreboard consumer.
   always @(negedge clk) begin
      logic [8:0] exp;
      if (rst) begin
         model_busy = 1'b0;
         model_done = 1'b0;
         busy_cnt   = 0;
         prev_start = 1'b0;
         sb.delete();
      end else begin
         model_done = 1'b0;
         if (bus_if.o_tx_start) begin
            starts++;
            check("start_gap_busy", {30'd0, prev_start, busy_at_edge}, 32'd0);
            exp = (sb.size() != 0) ? {1'b0, sb.pop_front()} : 9'h100;
            check("tx_data", {23'd0, 1'b0, bus_if.o_tx_data}, {23'd0, exp});
            model_busy = 1'b1;
            busy_cnt   = 3;
         end else if (busy_cnt != 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
               model_busy = 1'b0;
               model_done = 1'b1;
               dones++;
            end
         end
         prev_start = bus_if.o_tx_start;
      end
   end

   task automatic wr(input logic [7:0] d, input bit accept);
      bus_if.i_wr_en   = 1'b1;
      bus_if.i_wr_data = d;
      if (accept) sb.push_back(d);
      @(negedge clk);
      bus_if.i_wr_en   = 1'b0;
   endtask

   task automatic wait_drain(input int max_cyc);
      int n = 0;
      while ((sb.size() != 0 || busy_cnt != 0 || !bus_if.o_empty) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("drained_sb", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s0;
      int d0;
      bus_if.i_wr_en        = 1'b0;
      bus_if.i_wr_data      = 8'h00;
      bus_if.i_clr_overflow = 1'b0;
`ifdef UART_TX_FIFO_CTS_EN
      bus_if.i_cts_n        = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_empty",    bus_if.o_empty,    1);
      check("rst_full",     bus_if.o_full,     0);
      check("rst_count",    bus_if.o_count,    0);
      check("rst_overflow", bus_if.o_overflow, 0);
      check("rst_start",    bus_if.o_tx_start, 0);
      check("rst_txdata",   bus_if.o_tx_data,  0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Single byte: start exactly two edges after the write edge.
      wr(8'hA5, 1);
      check("t1_start_early", bus_if.o_tx_start, 0);
      check("t1_count1",      bus_if.o_count,    1);
      @(negedge clk);
      check("t1_start",  bus_if.o_tx_start, 1);
      check("t1_data",   bus_if.o_tx_data,  8'hA5);
      check("t1_empty_after_pop", bus_if.o_empty, 1);
      @(negedge clk);
      check("t1_start_single", bus_if.o_tx_start, 0);
      check("t1_data_hold",    bus_if.o_tx_data,  8'hA5);
      wait_drain(50);
      check("t1_empty", bus_if.o_empty, 1);
      check("t1_count", bus_if.o_count, 0);

      // Fill completely while the transmitter is held busy.
      hold_busy = 1'b1;
      s0 = starts;
      d0 = dones;
      for (int i = 0; i < DEPTH; i++) wr(8'(i), 1);
      check("t2_full",     bus_if.o_full,  1);
      check("t2_count",    bus_if.o_count, DEPTH);
      check("t2_nostart",  starts,         s0);

      // Overflow while full, clear, then set-beats-clear.
      wr(8'hFF, 0);
      check("t3_ovf_set",   bus_if.o_overflow, 1);
      check("t3_count",     bus_if.o_count,    DEPTH);
      bus_if.i_clr_overflow = 1'b1;
      @(negedge clk);
      bus_if.i_clr_overflow = 1'b0;
      check("t3_ovf_clr",   bus_if.o_overflow, 0);
      bus_if.i_clr_overflow = 1'b1;
      wr(8'hFF, 0);
      bus_if.i_clr_overflow = 1'b0;
      check("t3_set_wins",  bus_if.o_overflow, 1);
      bus_if.i_clr_overflow = 1'b1;
      @(negedge clk);
      bus_if.i_clr_overflow = 1'b0;
      check("t3_ovf_clr2",  bus_if.o_overflow, 0);

      hold_busy = 1'b0;
      wait_drain(400);
      check("t2_starts", starts - s0, DEPTH);
      check("t2_dones",  dones - d0,  DEPTH);
      check("t2_empty",  bus_if.o_empty, 1);

      // Interleaved writes and drains, pointers wrap more than twice.
      s0 = starts;
      for (int i = 0; i < 40; i++) begin
         wr(8'(i * 7 + 3), 1);
         repeat (4 + (i % 3)) @(negedge clk);
      end
      wait_drain(400);
      check("t4_starts",   starts - s0,       40);
      check("t4_overflow", bus_if.o_overflow, 0);
      check("t4_count",    bus_if.o_count,    0);

      // Reset while in D_WAIT with three bytes queued.
      for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i), 1);
      check("t5_count_pre", bus_if.o_count, 3);
      check("t5_busy_pre",  model_busy,     1);
      rst = 1'b1;
      @(negedge clk);
      check("t5_count", bus_if.o_count,    0);
      check("t5_empty", bus_if.o_empty,    1);
      check("t5_start", bus_if.o_tx_start, 0);
      @(negedge clk);
      rst = 1'b0;
      s0 = starts;
      repeat (30) @(negedge clk);
      check("t5_no_launch", starts, s0);
      check("t5_empty2",    bus_if.o_empty, 1);

`ifdef UART_TX_FIFO_CTS_EN
      // Flow control: hold, release with sync latency, mid-frame deassert.
      bus_if.i_cts_n = 1'b1;
      repeat (3) @(negedge clk);
      s0 = starts;
      d0 = dones;
      wr(8'h5A, 1);
      wr(8'h3C, 1);
      repeat (100) @(negedge clk);
      check("t6_held",       starts,         s0);
      check("t6_count_held", bus_if.o_count, 2);
      bus_if.i_cts_n = 1'b0;
      @(negedge clk);
      check("t6_lat1", bus_if.o_tx_start, 0);
      @(negedge clk);
      check("t6_lat2", bus_if.o_tx_start, 0);
      @(negedge clk);
      check("t6_lat3", bus_if.o_tx_start, 1);
      bus_if.i_cts_n = 1'b1;
      repeat (30) @(negedge clk);
      check("t6_one_frame",  starts - s0,    1);
      check("t6_frame_done", dones - d0,     1);
      check("t6_second_held", bus_if.o_count, 1);
      bus_if.i_cts_n = 1'b0;
      wait_drain(100);
      check("t6_all_sent", starts - s0, 2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and launch controller that sits directly upstream of the UART transmitter. It accepts bytes from the processor-side write port into a circular FIFO. It drains the FIFO one byte at a time into the transmitter using a single-cycle start pulse, then waits for the transmitter's busy/done handshake. This lets software queue up to DEPTH bytes without polling the transmitter per byte.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; localparam, derived, not overridable.

Ports:
- i_clk, input, 1, system clock.
- i_rst, input, 1, reset, synchronous, active-high.
- i_wr_en, input, 1, write strobe; one byte per cycle.
- i_wr_data, input, 8, byte to enqueue.
- i_clr_overflow, input, 1, clears the sticky overflow flag.
- o_full, output, 1, FIFO holds DEPTH entries.
- o_empty, output, 1, FIFO holds 0 entries.
- o_count, output, PTR_W+1, current entry count, 0..DEPTH.
- o_overflow, output, 1, sticky: a write was attempted while full.
- o_tx_data, output, 8, byte presented to the transmitter data input.
- o_tx_start, output, 1, single-cycle launch pulse to the transmitter.
- i_tx_busy, input, 1, transmitter busy (non-idle).
- i_tx_done, input, 1, transmitter one-cycle completion pulse.
- i_cts_n, input, 1, clear-to-send, active-low; present only with UART_TX_FIFO_CTS_EN.

Behaviour:
Reset:
- Applies when i_rst=1 at a clock edge.
- wr_ptr=0, rd_ptr=0, count=0.
- o_empty=1, o_full=0, o_overflow=0, o_tx_start=0, o_tx_data=8'h00.
- FSM=D_IDLE.
- Reset mid-transfer abandons the byte in flight; the transmitter shares i_rst.

Write side:
- i_wr_en=1 and not full: store i_wr_data at mem[wr_ptr], wr_ptr+1 (wraps modulo DEPTH), count+1.
- i_wr_en=1 while full: write dropped, no pointer change, o_overflow<=1. This holds even if a pop occurs in the same cycle; full is evaluated on the pre-edge count.
- i_clr_overflow=1 clears o_overflow. If a clear and a new overflow happen in the same cycle, set wins.

Flags:
- o_full = (count==DEPTH) and o_empty = (count==0), both driven from the registered count.
- Write and pop in the same cycle leave count unchanged and move both pointers.

Drain FSM (registered outputs):
- D_IDLE: if !o_empty && !i_tx_busy (and launch permitted), then at the next edge:
  - o_tx_data<=mem[rd_ptr], o_tx_start<=1
  - rd_ptr+1, count-1
  - go to D_LAUNCH
- D_LAUNCH: o_tx_start<=0. When i_tx_busy=1, go to D_WAIT.
- D_WAIT: when i_tx_done=1, go to D_IDLE.
- Unused state encoding: return to D_IDLE.

Launch timing and guarantees:
- Latency from a write into an empty, idle FIFO to o_tx_start=1 is 2 cycles: write edge, then launch edge.
- o_tx_data holds its value from the launch until the next launch.
- o_tx_start is never high for 2 consecutive cycles.
- No launch occurs while i_tx_busy=1.
- A byte popped at launch is never re-sent.

Back-to-back bytes:
- After i_tx_done, the next launch occurs 1 cycle later at the earliest (D_IDLE evaluation), so the inter-frame gap is 1-2 clocks of idle line.

Optional Feature:
Macro: UART_TX_FIFO_CTS_EN.
- Defined:
  - i_cts_n port exists, synchronised through 2 flops (synchroniser flops reset to 1).
  - D_IDLE launches only when the synchronised cts_n=0.
  - A byte already launched always completes; deassertion never aborts a frame.
- Undefined:
  - Port and synchroniser are absent.
  - Launch permission is always true.

Test Plan:
1. Reset, then write 8'hA5 with a transmitter model (busy 3 cycles after start, then done) -> o_tx_start pulses 2 cycles after the write with o_tx_data=8'hA5; o_empty returns to 1, o_count=0.
2. Burst of 16 writes 8'h00..8'h0F in consecutive cycles while busy is held high -> o_full=1, o_count=16, no start; release busy -> bytes launched in order 00..0F, exactly one start per done.
3. 17th write while full (8'hFF) -> o_overflow=1, o_count stays 16, 8'hFF never transmitted. Pulse i_clr_overflow -> o_overflow=0.
4. Wrap-around: 40 bytes written with interleaved drains, so pointers wrap twice -> transmitted sequence equals the written sequence, no loss or duplication.
5. Assert i_rst while in D_WAIT with 3 bytes queued -> next cycle o_count=0, o_empty=1, o_tx_start=0, no further launches.
6. With UART_TX_FIFO_CTS_EN: i_cts_n=1 with 2 bytes queued -> no start for 100 cycles. Drop i_cts_n -> first start 3 cycles later (2-flop sync plus launch edge). Raise i_cts_n mid-frame -> current frame completes, second byte is held.
